// File: rtl/exec_stage_n_if.sv
// exec_stage_n_if -- bundle of issue, result and FPU handshake signals for exec_stage_n.
//   master : upstream/downstream side (drives operands, interlock, fpu_ready)
//   slave  : the execute stage itself
// Lane 0 occupies the lowest bits of every packed bus.
interface exec_stage_n_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int RT_W  = 5
);
    logic                   interlock;
    logic [31:0]            pc;
    logic [32*LANES-1:0]    inst;
    logic [XLEN*LANES-1:0]  srca;
    logic [XLEN*LANES-1:0]  srcb;
    logic [4*LANES-1:0]     e_type;
    logic [RT_W*LANES-1:0]  rt;
    logic [LANES-1:0]       rt_flag;

    logic [31:0]            pc_out;
    logic [32*LANES-1:0]    inst_out;
    logic [XLEN*LANES-1:0]  tdata;
    logic [RT_W*LANES-1:0]  rt_out;
    logic [LANES-1:0]       rt_flag_out;

    logic [LANES-1:0]       fpu_valid;
    logic [LANES-1:0]       fpu_ready;
    logic [3*LANES-1:0]     fpu_op;
    logic [XLEN*LANES-1:0]  fpu_srca;
    logic [XLEN*LANES-1:0]  fpu_srcb;
    logic [RT_W*LANES-1:0]  fpu_rt;
    logic                   stall_out;

    modport master (
        output interlock, pc, inst, srca, srcb, e_type, rt, rt_flag, fpu_ready,
        input  pc_out, inst_out, tdata, rt_out, rt_flag_out,
               fpu_valid, fpu_op, fpu_srca, fpu_srcb, fpu_rt, stall_out
    );

    modport slave (
        input  interlock, pc, inst, srca, srcb, e_type, rt, rt_flag, fpu_ready,
        output pc_out, inst_out, tdata, rt_out, rt_flag_out,
               fpu_valid, fpu_op, fpu_srca, fpu_srcb, fpu_rt, stall_out
    );
endinterface

// File: rtl/exec_stage_n.sv
// exec_stage_n -- multi-lane execute stage: integer ALU per lane plus a
// valid/ready request port per lane towards an external FPU.
//   clk        : clock, all state on rising edge
//   rstn       : synchronous active-low reset
//   bus.slave  : issue inputs (pc, inst, srca/srcb, e_type, rt, rt_flag, interlock),
//                results (pc_out, inst_out, tdata, rt_out, rt_flag_out),
//                FPU request (fpu_valid/ready, fpu_op, fpu_srca/srcb, fpu_rt), stall_out
// Build option: define EXEC_MUL_EN to give op 15 a signed multiply; otherwise op 15
// passes srcb through like Nop and no multiplier exists.
//
// Per-lane FPU FSM:
//   state  | meaning
//   S_IDLE | no request, or request offered this cycle not yet seen stalled
//   S_WAIT | request outstanding with fpu_ready low, payload frozen
module exec_stage_n #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int RT_W  = 5
) (
    input  logic           clk,
    input  logic           rstn,
    exec_stage_n_if.slave  bus
);
    localparam int          SH_W   = $clog2(XLEN);
    localparam logic [31:0] BUBBLE = 32'hE000_0000;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} fpu_state_e;

    fpu_state_e             state_q [LANES];
    logic [31:0]            pc_out_q;
    logic [32*LANES-1:0]    inst_out_q;
    logic [XLEN*LANES-1:0]  tdata_q;
    logic [RT_W*LANES-1:0]  rt_out_q;
    logic [LANES-1:0]       rt_flag_out_q;
    logic [LANES-1:0]       fpu_valid_q;
    logic [3*LANES-1:0]     fpu_op_q;
    logic [XLEN*LANES-1:0]  fpu_srca_q;
    logic [XLEN*LANES-1:0]  fpu_srcb_q;
    logic [RT_W*LANES-1:0]  fpu_rt_q;

    logic [XLEN*LANES-1:0]  tdata_d;
    logic [3*LANES-1:0]     fpu_op_d;
    logic [LANES-1:0]       is_fop;
    logic                   stall;
    logic                   capture;

    function automatic logic [XLEN-1:0] alu(input logic [3:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (op)
            4'd1:    alu = a + b;
            4'd2:    alu = a - b;
            4'd3:    alu = $unsigned($signed(a) >>> sh);
            4'd4:    alu = a << sh;
            4'd12:   alu = a & b;
            4'd13:   alu = a | b;
            4'd14:   alu = a >> sh;
`ifdef EXEC_MUL_EN
            4'd15:   alu = $unsigned($signed(a) * $signed(b));
`endif
            // Nop and all F-ops forward srcb as the integer result
            default: alu = b;
        endcase
    endfunction

    always_comb begin
        tdata_d  = '0;
        fpu_op_d = '0;
        is_fop   = '0;
        for (int l = 0; l < LANES; l++) begin
            tdata_d[l*XLEN +: XLEN] = alu(bus.e_type[l*4 +: 4],
                                          bus.srca[l*XLEN +: XLEN],
                                          bus.srcb[l*XLEN +: XLEN]);
            is_fop[l] = (bus.e_type[l*4 +: 4] >= 4'd5) && (bus.e_type[l*4 +: 4] <= 4'd11);
            // low three bits of (e_type - 5) only depend on the low three bits
            fpu_op_d[l*3 +: 3] = bus.e_type[l*4 +: 3] - 3'd5;
        end
    end

    assign stall   = |(fpu_valid_q & ~bus.fpu_ready);
    assign capture = !bus.interlock && !stall;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_out_q      <= '0;
            inst_out_q    <= {LANES{BUBBLE}};
            rt_flag_out_q <= '0;
            fpu_valid_q   <= '0;
            for (int l = 0; l < LANES; l++) state_q[l] <= S_IDLE;
        end else begin
            pc_out_q   <= capture ? bus.pc : 32'd0;
            inst_out_q <= capture ? bus.inst : {LANES{BUBBLE}};
            for (int l = 0; l < LANES; l++) begin
                case (state_q[l])
                    S_IDLE:  if (fpu_valid_q[l] && !bus.fpu_ready[l]) state_q[l] <= S_WAIT;
                    S_WAIT:  if (bus.fpu_ready[l]) state_q[l] <= S_IDLE;
                    default: state_q[l] <= S_IDLE;
                endcase

                // a completed transfer retires the request unless a new F-op replaces it below
                if (fpu_valid_q[l] && bus.fpu_ready[l]) fpu_valid_q[l] <= 1'b0;

                if (capture) begin
                    tdata_q[l*XLEN +: XLEN] <= tdata_d[l*XLEN +: XLEN];
                    rt_out_q[l*RT_W +: RT_W] <= bus.rt[l*RT_W +: RT_W];
                    rt_flag_out_q[l]         <= bus.rt_flag[l] & ~is_fop[l];
                    if (is_fop[l]) begin
                        fpu_valid_q[l]              <= 1'b1;
                        fpu_op_q[l*3 +: 3]          <= fpu_op_d[l*3 +: 3];
                        fpu_srca_q[l*XLEN +: XLEN]  <= bus.srca[l*XLEN +: XLEN];
                        fpu_srcb_q[l*XLEN +: XLEN]  <= bus.srcb[l*XLEN +: XLEN];
                        fpu_rt_q[l*RT_W +: RT_W]    <= bus.rt[l*RT_W +: RT_W];
                    end
                end else begin
                    rt_flag_out_q[l] <= 1'b0;
                end
            end
        end
    end

    assign bus.pc_out      = pc_out_q;
    assign bus.inst_out    = inst_out_q;
    assign bus.tdata       = tdata_q;
    assign bus.rt_out      = rt_out_q;
    assign bus.rt_flag_out = rt_flag_out_q;
    assign bus.fpu_valid   = fpu_valid_q;
    assign bus.fpu_op      = fpu_op_q;
    assign bus.fpu_srca    = fpu_srca_q;
    assign bus.fpu_srcb    = fpu_srcb_q;
    assign bus.fpu_rt      = fpu_rt_q;
    assign bus.stall_out   = stall;
endmodule

// File: tb/tb_exec_stage_n.sv
module tb_exec_stage_n;
    localparam int          LANES = 2;
    localparam int          XLEN  = 32;
    localparam int          RT_W  = 5;
    localparam logic [31:0] BUB   = 32'hE000_0000;
    localparam logic [63:0] BUB2  = {BUB, BUB};

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    exec_stage_n_if #(.LANES(LANES), .XLEN(XLEN), .RT_W(RT_W)) bus ();
    exec_stage_n #(.LANES(LANES), .XLEN(XLEN), .RT_W(RT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0]       s_op   [LANES];
    logic [31:0]      s_a    [LANES];
    logic [31:0]      s_b    [LANES];
    logic [4:0]       s_rt   [LANES];
    logic [LANES-1:0] s_flag;
    logic [31:0]      s_pc;
    logic [63:0]      s_inst;

    // reference ALU from arithmetic definitions (floor division for Sra, powers of two for shifts)
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, p2;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        sh = int'(b % 32);
        p2 = 1;
        for (int i = 0; i < sh; i++) p2 = p2 * 2;
        case (op)
            1:  return 32'(sa + sb);
            2:  return 32'(sa - sb);
            3:  return 32'((sa < 0 ? sa - (p2 - 1) : sa) / p2);
            4:  return 32'(ua * p2);
            12: return a & b;
            13: return a | b;
            14: return 32'(ua / p2);
`ifdef EXEC_MUL_EN
            15: return 32'(sa * sb);
`endif
            default: return b;
        endcase
    endfunction

    task automatic apply();
        bus.pc      = s_pc;
        bus.inst    = s_inst;
        bus.rt_flag = s_flag;
        for (int l = 0; l < LANES; l++) begin
            bus.e_type[l*4 +: 4]    = s_op[l];
            bus.srca[l*XLEN +: XLEN] = s_a[l];
            bus.srcb[l*XLEN +: XLEN] = s_b[l];
            bus.rt[l*RT_W +: RT_W]   = s_rt[l];
        end
    endtask

    task automatic set_nop();
        for (int l = 0; l < LANES; l++) begin
            s_op[l] = 4'd0; s_a[l] = 32'd0; s_b[l] = 32'd0; s_rt[l] = 5'd0;
        end
        s_flag = '0; s_pc = 32'd0; s_inst = 64'd0;
        apply();
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        set_nop();
        bus.interlock = 1'b0;
        bus.fpu_ready = 2'b11;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        set_nop();
        bus.interlock = 1'b0;
        bus.fpu_ready = 2'b00;
        rstn = 1'b0;
        step();
        n_chk++; if (bus.pc_out !== 32'd0) $display("FAIL rst_pc got %h exp 0", bus.pc_out); else n_pass++;
        n_chk++; if (bus.inst_out !== BUB2) $display("FAIL rst_inst got %h exp %h", bus.inst_out, BUB2); else n_pass++;
        n_chk++; if (bus.rt_flag_out !== 2'b00) $display("FAIL rst_flag got %b exp 00", bus.rt_flag_out); else n_pass++;
        n_chk++; if (bus.fpu_valid !== 2'b00) $display("FAIL rst_valid got %b exp 00", bus.fpu_valid); else n_pass++;
        n_chk++; if (bus.stall_out !== 1'b0) $display("FAIL rst_stall got %b exp 0", bus.stall_out); else n_pass++;
        rstn = 1'b1;
    endtask

    task automatic test_alu_directed();
        reset_dut();
        s_op[0] = 4'd1; s_a[0] = 32'd7; s_b[0] = 32'hFFFF_FFFD; s_rt[0] = 5'd3;
        s_op[1] = 4'd4; s_a[1] = 32'd1; s_b[1] = 32'd33;        s_rt[1] = 5'd9;
        s_flag = 2'b11; s_pc = 32'h0000_0100; s_inst = 64'h1111_2222_3333_4444;
        apply();
        step();
        n_chk++; if (bus.tdata !== {32'd2, 32'd4}) $display("FAIL alu_tdata got %h exp %h", bus.tdata, {32'd2, 32'd4}); else n_pass++;
        n_chk++; if (bus.rt_flag_out !== 2'b11) $display("FAIL alu_flag got %b exp 11", bus.rt_flag_out); else n_pass++;
        n_chk++; if (bus.rt_out !== {5'd9, 5'd3}) $display("FAIL alu_rt got %h exp %h", bus.rt_out, {5'd9, 5'd3}); else n_pass++;
        n_chk++; if (bus.pc_out !== 32'h100) $display("FAIL alu_pc got %h exp 100", bus.pc_out); else n_pass++;
        n_chk++; if (bus.inst_out !== 64'h1111_2222_3333_4444) $display("FAIL alu_inst got %h", bus.inst_out); else n_pass++;
    endtask

    task automatic test_fmul();
        reset_dut();
        bus.fpu_ready = 2'b11;
        s_op[0] = 4'd1; s_a[0] = 32'd1; s_b[0] = 32'd1; s_rt[0] = 5'd1;
        s_op[1] = 4'd7; s_a[1] = 32'h4040_0000; s_b[1] = 32'h1234_5678; s_rt[1] = 5'd17;
        s_flag = 2'b11; s_pc = 32'h40;
        apply();
        step();
        n_chk++; if (bus.fpu_valid !== 2'b10) $display("FAIL fmul_valid got %b exp 10", bus.fpu_valid); else n_pass++;
        n_chk++; if (bus.fpu_op[5:3] !== 3'd2) $display("FAIL fmul_op got %0d exp 2", bus.fpu_op[5:3]); else n_pass++;
        n_chk++; if (bus.rt_flag_out !== 2'b01) $display("FAIL fmul_flag got %b exp 01", bus.rt_flag_out); else n_pass++;
        n_chk++; if (bus.stall_out !== 1'b0) $display("FAIL fmul_stall got %b exp 0", bus.stall_out); else n_pass++;
        n_chk++; if (bus.tdata[63:32] !== 32'h1234_5678) $display("FAIL fmul_tdata got %h exp 12345678", bus.tdata[63:32]); else n_pass++;
        n_chk++; if (bus.fpu_srca[63:32] !== 32'h4040_0000 || bus.fpu_rt[9:5] !== 5'd17)
            $display("FAIL fmul_payload got %h/%0d exp 40400000/17", bus.fpu_srca[63:32], bus.fpu_rt[9:5]); else n_pass++;
        set_nop();
        step();
        n_chk++; if (bus.fpu_valid !== 2'b00) $display("FAIL fmul_drop got %b exp 00", bus.fpu_valid); else n_pass++;
    endtask

    task automatic test_fdiv_stall();
        reset_dut();
        bus.fpu_ready = 2'b00;
        s_op[0] = 4'd8; s_a[0] = 32'hAAAA_0001; s_b[0] = 32'h5555_0002; s_rt[0] = 5'd4;
        s_pc = 32'h200;
        apply();
        step();
        n_chk++; if (bus.fpu_valid !== 2'b01 || bus.fpu_op[2:0] !== 3'd3)
            $display("FAIL fdiv_issue got %b/%0d exp 01/3", bus.fpu_valid, bus.fpu_op[2:0]); else n_pass++;
        n_chk++; if (bus.pc_out !== 32'h200) $display("FAIL fdiv_pc got %h exp 200", bus.pc_out); else n_pass++;
        n_chk++; if (bus.stall_out !== 1'b1) $display("FAIL fdiv_stall_c1 got %b exp 1", bus.stall_out); else n_pass++;
        s_op[0] = 4'd1; s_a[0] = 32'd5; s_b[0] = 32'd6; s_pc = 32'h300; s_inst = 64'hDEAD_BEEF_0000_0001;
        apply();
        for (int c = 2; c <= 3; c++) begin
            step();
            n_chk++; if (bus.stall_out !== 1'b1) $display("FAIL fdiv_stall_c%0d got %b exp 1", c, bus.stall_out); else n_pass++;
            n_chk++; if (bus.inst_out !== BUB2 || bus.pc_out !== 32'd0)
                $display("FAIL fdiv_bubble_c%0d got %h/%h exp %h/0", c, bus.inst_out, bus.pc_out, BUB2); else n_pass++;
            n_chk++; if (bus.fpu_valid[0] !== 1'b1 || bus.fpu_srca[31:0] !== 32'hAAAA_0001 || bus.fpu_srcb[31:0] !== 32'h5555_0002)
                $display("FAIL fdiv_hold_c%0d got %b %h %h", c, bus.fpu_valid[0], bus.fpu_srca[31:0], bus.fpu_srcb[31:0]); else n_pass++;
        end
        bus.fpu_ready = 2'b01;
        #1;
        n_chk++; if (bus.stall_out !== 1'b0) $display("FAIL fdiv_release got %b exp 0", bus.stall_out); else n_pass++;
        step();
        n_chk++; if (bus.fpu_valid !== 2'b00) $display("FAIL fdiv_drop got %b exp 00", bus.fpu_valid); else n_pass++;
        n_chk++; if (bus.tdata[31:0] !== 32'd11 || bus.pc_out !== 32'h300)
            $display("FAIL fdiv_after got %0d/%h exp 11/300", bus.tdata[31:0], bus.pc_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        reset_dut();
        bus.fpu_ready = 2'b11;
        s_op[0] = 4'd5; s_a[0] = 32'h10; apply();
        step();
        n_chk++; if (bus.fpu_valid !== 2'b01 || bus.fpu_op[2:0] !== 3'd0)
            $display("FAIL b2b_first got %b/%0d exp 01/0", bus.fpu_valid, bus.fpu_op[2:0]); else n_pass++;
        s_op[0] = 4'd6; s_a[0] = 32'h20; apply();
        step();
        n_chk++; if (bus.fpu_valid !== 2'b01 || bus.fpu_op[2:0] !== 3'd1 || bus.fpu_srca[31:0] !== 32'h20)
            $display("FAIL b2b_second got %b/%0d/%h exp 01/1/20", bus.fpu_valid, bus.fpu_op[2:0], bus.fpu_srca[31:0]); else n_pass++;
        s_op[0] = 4'd0; apply();
        step();
        n_chk++; if (bus.fpu_valid !== 2'b00) $display("FAIL b2b_drop got %b exp 00", bus.fpu_valid); else n_pass++;
    endtask

    task automatic test_interlock();
        reset_dut();
        s_op[0] = 4'd1; s_a[0] = 32'd2; s_b[0] = 32'd3;
        s_op[1] = 4'd13; s_a[1] = 32'hF0; s_b[1] = 32'h0F;
        s_flag = 2'b11; s_pc = 32'h500; apply();
        step();
        s_op[0] = 4'd2; s_a[0] = 32'd10; s_b[0] = 32'd4; s_pc = 32'h600; apply();
        bus.interlock = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            step();
            n_chk++; if (bus.pc_out !== 32'd0 || bus.inst_out !== BUB2 || bus.rt_flag_out !== 2'b00)
                $display("FAIL ilk_bubble_c%0d got %h/%h/%b", c, bus.pc_out, bus.inst_out, bus.rt_flag_out); else n_pass++;
            n_chk++; if (bus.tdata !== {32'hFF, 32'd5}) $display("FAIL ilk_hold_c%0d got %h exp %h", c, bus.tdata, {32'hFF, 32'd5}); else n_pass++;
        end
        bus.interlock = 1'b0;
        step();
        n_chk++; if (bus.pc_out !== 32'h600 || bus.tdata[31:0] !== 32'd6)
            $display("FAIL ilk_release got %h/%0d exp 600/6", bus.pc_out, bus.tdata[31:0]); else n_pass++;
        // pending request keeps its handshake while interlocked
        bus.fpu_ready = 2'b00;
        s_op[0] = 4'd9; apply();
        step();
        bus.interlock = 1'b1;
        step();
        n_chk++; if (bus.fpu_valid !== 2'b01 || bus.stall_out !== 1'b1)
            $display("FAIL ilk_fpu_persist got %b/%b exp 01/1", bus.fpu_valid, bus.stall_out); else n_pass++;
        bus.fpu_ready = 2'b01;
        step();
        n_chk++; if (bus.fpu_valid !== 2'b00) $display("FAIL ilk_fpu_xfer got %b exp 00", bus.fpu_valid); else n_pass++;
        bus.interlock = 1'b0;
    endtask

    task automatic test_reset_wait();
        reset_dut();
        bus.fpu_ready = 2'b00;
        s_op[1] = 4'd10; apply();
        step();
        step();
        n_chk++; if (bus.fpu_valid !== 2'b10 || bus.stall_out !== 1'b1)
            $display("FAIL rw_wait got %b/%b exp 10/1", bus.fpu_valid, bus.stall_out); else n_pass++;
        rstn = 1'b0;
        step();
        n_chk++; if (bus.fpu_valid !== 2'b00 || bus.stall_out !== 1'b0)
            $display("FAIL rw_after got %b/%b exp 00/0", bus.fpu_valid, bus.stall_out); else n_pass++;
        rstn = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] exp_v;
`ifdef EXEC_MUL_EN
        exp_v = 32'hFFFF_FFEC;
`else
        exp_v = 32'd5;
`endif
        reset_dut();
        s_op[0] = 4'd15; s_a[0] = 32'hFFFF_FFFC; s_b[0] = 32'd5; apply();
        step();
        n_chk++; if (bus.tdata[31:0] !== exp_v) $display("FAIL mul got %h exp %h", bus.tdata[31:0], exp_v); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0]      e_pc;
        logic [63:0]      e_inst;
        logic [31:0]      e_td  [LANES];
        logic [4:0]       e_rt  [LANES];
        logic [2:0]       e_op  [LANES];
        logic [31:0]      e_fa  [LANES];
        logic [31:0]      e_fb  [LANES];
        logic [4:0]       e_frt [LANES];
        logic [LANES-1:0] e_flag, e_v, rdy;
        logic             il, stall_e, cap;
        reset_dut();
        e_v = '0; e_flag = '0;
        for (int it = 0; it < 300; it++) begin
            for (int l = 0; l < LANES; l++) begin
                s_op[l] = 4'($urandom_range(0, 15));
                s_a[l]  = $urandom;
                s_b[l]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
                s_rt[l] = 5'($urandom);
            end
            s_flag = 2'($urandom); s_pc = $urandom; s_inst = {$urandom, $urandom};
            apply();
            il  = (it == 0) ? 1'b0 : ($urandom_range(0, 4) == 0);
            rdy = (it == 0) ? 2'b11 : 2'($urandom);
            bus.interlock = il;
            bus.fpu_ready = rdy;
            #1;
            stall_e = |(e_v & ~rdy);
            n_chk++; if (bus.stall_out !== stall_e) $display("FAIL rnd_stall it%0d got %b exp %b", it, bus.stall_out, stall_e); else n_pass++;
            cap = !il && !stall_e;
            for (int l = 0; l < LANES; l++) begin
                if (e_v[l] && rdy[l]) e_v[l] = 1'b0;
                if (cap) begin
                    e_rt[l] = s_rt[l];
                    if (s_op[l] >= 4'd5 && s_op[l] <= 4'd11) begin
                        e_td[l] = s_b[l]; e_flag[l] = 1'b0; e_v[l] = 1'b1;
                        e_op[l] = 3'(int'(s_op[l]) - 5);
                        e_fa[l] = s_a[l]; e_fb[l] = s_b[l]; e_frt[l] = s_rt[l];
                    end else begin
                        e_td[l] = ref_alu(int'(s_op[l]), s_a[l], s_b[l]);
                        e_flag[l] = s_flag[l];
                    end
                end else begin
                    e_flag[l] = 1'b0;
                end
            end
            e_pc   = cap ? s_pc : 32'd0;
            e_inst = cap ? s_inst : BUB2;
            @(posedge clk); #1;
            n_chk++; if (bus.pc_out !== e_pc || bus.inst_out !== e_inst)
                $display("FAIL rnd_pc it%0d got %h/%h exp %h/%h", it, bus.pc_out, bus.inst_out, e_pc, e_inst); else n_pass++;
            n_chk++; if (bus.rt_flag_out !== e_flag || bus.fpu_valid !== e_v)
                $display("FAIL rnd_flags it%0d got %b/%b exp %b/%b", it, bus.rt_flag_out, bus.fpu_valid, e_flag, e_v); else n_pass++;
            n_chk++; if (bus.tdata !== {e_td[1], e_td[0]} || bus.rt_out !== {e_rt[1], e_rt[0]})
                $display("FAIL rnd_tdata it%0d got %h/%h exp %h/%h", it, bus.tdata, bus.rt_out, {e_td[1], e_td[0]}, {e_rt[1], e_rt[0]}); else n_pass++;
            for (int l = 0; l < LANES; l++) begin
                if (e_v[l]) begin
                    n_chk++;
                    if (bus.fpu_op[l*3 +: 3] !== e_op[l] || bus.fpu_srca[l*32 +: 32] !== e_fa[l] ||
                        bus.fpu_srcb[l*32 +: 32] !== e_fb[l] || bus.fpu_rt[l*5 +: 5] !== e_frt[l])
                        $display("FAIL rnd_payload it%0d lane%0d got %0d %h %h %0d exp %0d %h %h %0d", it, l,
                                 bus.fpu_op[l*3 +: 3], bus.fpu_srca[l*32 +: 32], bus.fpu_srcb[l*32 +: 32], bus.fpu_rt[l*5 +: 5],
                                 e_op[l], e_fa[l], e_fb[l], e_frt[l]);
                    else n_pass++;
                end
            end
        end
        bus.interlock = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.interlock = 1'b0;
        bus.fpu_ready = 2'b00;
        set_nop();
        test_reset();
        test_alu_directed();
        test_fmul();
        test_fdiv_stall();
        test_back_to_back();
        test_interlock();
        test_reset_wait();
        test_mul();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/exec_stage_n.md
EXEC_STAGE_N -- requirements
Module: exec_stage_n

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes; lane 0 occupies the lowest bits of every packed bus.
REQ-002 Parameter XLEN, default 32, operand/result width; RT_W, default 5, register index width.
REQ-003 clk  in  1  clock; one clock, all state updates on rising edge.
REQ-004 rstn  in  1  synchronous active-low reset.
REQ-005 interlock  in  1  downstream hold; no capture, bubble to next stage.
REQ-006 pc / pc_out  in/out  32  instruction-pair PC, passed through.
REQ-007 inst / inst_out  in/out  32*LANES  instruction bundle, passed through.
REQ-008 srca, srcb  in  XLEN*LANES  per-lane operands (signed).
REQ-009 e_type  in  4*LANES  per-lane op code; rt  in  RT_W*LANES; rt_flag  in  LANES.
REQ-010 tdata  out  XLEN*LANES  integer result; rt_out  out  RT_W*LANES; rt_flag_out  out  LANES.
REQ-011 fpu_valid  out  LANES; fpu_ready  in  LANES; fpu_op  out  3*LANES; fpu_srca, fpu_srcb  out  XLEN*LANES; fpu_rt  out  RT_W*LANES.
REQ-012 stall_out  out  1  asserted while any lane holds an unaccepted FPU request.

Function
REQ-013 Op codes: 0 Nop(srcb), 1 Add, 2 Sub, 3 Sra, 4 Sll, 5 Fadd, 6 Fsub, 7 Fmul, 8 Fdiv, 9 Fsqrt, 10 Ftoi, 11 Itof, 12 And, 13 Or, 14 Srl, 15 Mul.
REQ-014 Add/Sub wrap modulo 2^XLEN; shift amount is srcb[$clog2(XLEN)-1:0], upper bits ignored.
REQ-015 Capture condition: rstn=1, interlock=0, stall_out=0; on capture all outputs register new values, latency 1 cycle.
REQ-016 Integer op captured: tdata=result, rt_out=rt, rt_flag_out=rt_flag.
REQ-017 F-op (5-11) captured: rt_flag_out=0 for that lane, tdata=srcb; fpu_valid=1, fpu_op=e_type-5, fpu_srca/srcb/rt registered.
REQ-018 Per-lane FPU FSM IDLE/WAIT: IDLE->WAIT when fpu_valid=1 and fpu_ready=0; WAIT->IDLE on fpu_ready=1.
REQ-019 fpu_valid and fpu payload held stable while fpu_ready=0; a transfer occurs on any cycle fpu_valid & fpu_ready.
REQ-020 After transfer with no new F-op captured, fpu_valid drops next cycle; back-to-back F-ops keep fpu_valid high.
REQ-021 stall_out = OR over lanes of (fpu_valid & ~fpu_ready), combinational; upstream treats it as interlock.
REQ-022 When not capturing (interlock or stall_out): pc_out=0, inst_out = each lane 32'hE000_0000, rt_flag_out=0; tdata/rt_out hold.
REQ-023 interlock with pending FPU request: request persists, handshake continues unaffected.
REQ-024 Lanes independent; two lanes may issue F-ops same cycle, each to its own port.

Reset
REQ-025 rstn=0 at clock edge: rt_flag_out=0, fpu_valid=0, all FSMs IDLE, pc_out=0, inst_out=bubble; tdata, rt_out, fpu payload undefined-hold.
REQ-026 Reset mid-handshake discards pending request; stall_out=0 the cycle after.

Configuration
REQ-027 Macro EXEC_MUL_EN: defined -> op 15 returns low XLEN bits of signed srca*srcb, 1-cycle latency; undefined -> op 15 behaves as Nop (tdata=srcb), no multiplier instantiated.

Verification
REQ-028 Lane0 Add 7,-3; lane1 Sll 1,33 -> next cycle tdata0=4, tdata1=2, rt_flag_out as driven.
REQ-029 Lane1 Fmul, fpu_ready1=1 -> fpu_valid1=1 one cycle, fpu_op1=2, rt_flag_out1=0, stall_out=0.
REQ-030 Lane0 Fdiv with fpu_ready0=0 for 3 cycles -> stall_out high 3 cycles, payload stable, inst_out bubble cycles 2-3, valid drops after ready.
REQ-031 interlock=1 for 2 cycles -> pc_out=0, inst_out=E000_0000E000_0000, rt_flag_out=00; inputs captured after release.
REQ-032 rstn=0 during WAIT -> fpu_valid=0, stall_out=0 next cycle.
REQ-033 Op 15 srca=-4, srcb=5 -> tdata=-20 with EXEC_MUL_EN, tdata=5 without.
